alu_compare_sweeper: RTL and testbench
======================================

# alu_compare_sweeper

Synthesizable self-test engine for the ALU flag logic. It drives an external ALU with a subtract operation over a sweep of operand pairs: exhaustive or LFSR-random, at parametrised width and latency. For each pair it checks ten eq/unsigned/signed compare predicates derived from the returned flags against golden compares. It counts vectors and errors and captures the first failing pair. It sits beside the `Alu` in test builds and replaces the simulation-only, full-word sweep.

## Interface
- `WIDTH`, 8: operand width; legal 2..16.
- `ALU_LATENCY`, 0: cycles from operands stable to flags valid; legal 0..15.
- `OPER_WIDTH`, 4: width of the ALU operation code.
- `OPER_SUB`, 1: subtract operation code driven on `alu_oper`.
- `FLAG_Z` / `FLAG_C` / `FLAG_V` / `FLAG_N`, 0 / 1 / 2 / 3: bit positions inside the 4-bit flag vector.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- `abort`  in  1  stops an active sweep.
- `mode`  in  1  0 = exhaustive, 1 = random; sampled on `start`.
- `seed`  in  32  LFSR seed; sampled on `start`; 0 is replaced by 1.
- `num_vectors`  in  32  random-mode pair count; sampled on `start`.
- `alu_a`, `alu_b`  out  WIDTH  operands, registered.
- `alu_oper`  out  OPER_WIDTH  constant `OPER_SUB`.
- `alu_flags_in`  out  4  constant 0.
- `alu_flags_out`  in  4  flags returned by the ALU.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep completed; held high.
- `vec_count`  out  32  pairs checked; wraps modulo 2^32.
- `err_count`  out  16  failing pairs; saturates at 0xFFFF.
- `fail_valid`  out  1  a failure has been captured.
- `fail_a`, `fail_b`  out  WIDTH  operands of the first failing pair.
- `fail_flags`  out  4  flags of the first failing pair.
- `fail_mask`  out  10  mismatching predicates of the first failing pair.

## Operation
- States: IDLE, DRIVE, WAIT, CHECK, DONE.
- Reset state is IDLE. Every output resets to 0 except `alu_oper`, which is `OPER_SUB`.
- IDLE or DONE + `start`:
  - Clears `done`, counters and all `fail_*` outputs.
  - Exhaustive mode: operands start at a=0, b=0.
  - Random mode: LFSR is loaded with `seed`. If `num_vectors`==0, go straight to DONE with zero counts.
  - Otherwise go to DRIVE.
- `start` while `busy` is ignored.
- DRIVE: operands are stable. Latency counter loads `ALU_LATENCY`. Go to WAIT if `ALU_LATENCY`>0, else go to CHECK.
- WAIT: counter decrements. Go to CHECK when it reaches 0.
- CHECK: sample `alu_flags_out` and evaluate predicates.
  - Flag-derived predicates:
    - eq: Z.
    - ne: !Z.
    - ult: !C.
    - ule: !C|Z.
    - ugt: C&!Z.
    - uge: C.
    - slt: N!=V.
    - sle: (N!=V)|Z.
    - sgt: (N==V)&!Z.
    - sge: N==V.
  - Golden predicates: native unsigned and signed compares of `alu_a` against `alu_b` at WIDTH bits.
  - mask[i] = derived XOR golden. Bit order 0..9: eq, ne, ult, ule, ugt, uge, slt, sle, sgt, sge.
  - `vec_count`++ on every check.
  - Nonzero mask: `err_count`++ (saturating). If `fail_valid`==0, capture the pair, flags and mask, and set `fail_valid`.
  - Advance, then go to DRIVE, or to DONE on the last pair.
- Exhaustive advance: b increments; when b wraps, a increments. The last pair is a=b=all-ones, giving 2^(2·WIDTH) pairs in total.
- Random advance:
  - 32-bit Galois LFSR, taps 32,22,2,1 (mask 0x80200003), shifts once per CHECK.
  - a = lfsr[WIDTH-1:0], b = lfsr[2·WIDTH-1:WIDTH]. The first pair uses `seed`.
  - The last pair is the `num_vectors`-th.
- DONE: `done`=1, `busy`=0. All results hold until the next `start`.
- `abort` while busy: go to IDLE next cycle. Counters and `fail_*` are retained; `done` stays 0.
- `abort` has priority over a same-cycle CHECK update: that pair is not counted.

## Timing
- `busy` is high from the cycle after `start` until DONE or IDLE is entered.
- Each pair costs 2+`ALU_LATENCY` cycles.
- `done` rises N·(2+`ALU_LATENCY`) cycles after the `start` edge, where N is the pair count.
- `vec_count`, `err_count` and `fail_*` update on the CHECK clock edge and are visible the next cycle.
- `rst_n` low at any time returns to IDLE asynchronously and clears all outputs.

## Test plan
- WIDTH=4, LAT=0, exhaustive, correct ALU model -> `done` 512 cycles after `start`; `vec_count`=256, `err_count`=0, `fail_valid`=0.
- WIDTH=4, LAT=2, ALU model forcing C=1 only at a=3, b=5 -> `err_count`=1, `fail_a`=3, `fail_b`=5, `fail_mask`=0x03C; `done` after 1024 cycles.
- WIDTH=8, LAT=1, ALU model with V stuck at 0 -> first failure at a=0x00, b=0x80; `fail_mask`=0x3C0.
- WIDTH=8, LAT=0, random, seed=0, `num_vectors`=1000 -> behaves as seed=1; `vec_count`=1000, `err_count`=0; `done` 2000 cycles after `start`.
- WIDTH=8 exhaustive, `abort` at cycle 100 after `start` -> IDLE, `busy`=0, `done`=0, `vec_count`=50. A following `start` restarts with `vec_count` cleared.
- `rst_n` pulsed low mid-sweep -> all outputs 0 immediately; `start` while busy is ignored (`vec_count` keeps counting).

Source files
------------

// File: rtl/alu_compare_sweeper.sv
// alu_compare_sweeper
// Self-test engine for ALU flag logic. It drives an external ALU with a
// subtract over a sweep of operand pairs, either exhaustive or LFSR-random.
// For each pair it derives ten compare predicates from the returned Z/C/V/N
// flags and checks them against native compares of the operands.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, abort          begin a sweep (from IDLE/DONE) / stop an active sweep
//   mode, seed            0 = exhaustive, 1 = random; LFSR seed (0 -> 1)
//   num_vectors           pair count for random mode
//   alu_a, alu_b          registered operands to the ALU
//   alu_oper              constant subtract opcode
//   alu_flags_in          constant 0 flag input to the ALU
//   alu_flags_out         flags returned by the ALU
//   busy, done            sweep in progress / sweep complete (held)
//   vec_count, err_count  pairs checked (wrapping) / failing pairs (saturating)
//   fail_valid, fail_a, fail_b, fail_flags, fail_mask
//                         capture of the first failing pair
module alu_compare_sweeper #(
  parameter int WIDTH       = 8,
  parameter int ALU_LATENCY = 0,
  parameter int OPER_WIDTH  = 4,
  parameter int OPER_SUB    = 1,
  parameter int FLAG_Z      = 0,
  parameter int FLAG_C      = 1,
  parameter int FLAG_V      = 2,
  parameter int FLAG_N      = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [31:0]           seed,
  input  logic [31:0]           num_vectors,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [OPER_WIDTH-1:0] alu_oper,
  output logic [3:0]            alu_flags_in,
  input  logic [3:0]            alu_flags_out,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           vec_count,
  output logic [15:0]           err_count,
  output logic                  fail_valid,
  output logic [WIDTH-1:0]      fail_a,
  output logic [WIDTH-1:0]      fail_b,
  output logic [3:0]            fail_flags,
  output logic [9:0]            fail_mask
);

  localparam logic [OPER_WIDTH-1:0] OPER_CODE = OPER_WIDTH'(OPER_SUB);
  localparam logic [3:0]            LAT       = 4'(ALU_LATENCY);
  localparam logic [31:0]           LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q;
  logic [31:0]      lfsr_q;
  logic [31:0]      lfsr_nx;
  logic [31:0]      remaining_q;
  logic [3:0]       lat_cnt_q;
  logic             mode_q;
  logic [31:0]      seed_eff;
  logic             last_pair;
  logic             flag_z, flag_c, flag_v, flag_n, sign_lt;
  logic [9:0]       derived, golden, mask;

  assign alu_a        = a_q;
  assign alu_b        = b_q;
  assign alu_oper     = OPER_CODE;
  assign alu_flags_in = 4'b0000;
  assign busy         = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
  assign done         = (state == S_DONE);

  // A zero seed would lock the LFSR at zero forever.
  assign seed_eff = (seed == 32'd0) ? 32'd1 : seed;

  // Right-shifting Galois LFSR; the feedback bit toggles the tap positions.
  assign lfsr_nx = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

  assign last_pair = mode_q ? (remaining_q == 32'd1) : ((&a_q) && (&b_q));

  // Predicates derived from the ALU flags versus native compares of the
  // operands; any disagreement sets the corresponding mask bit.
  always_comb begin
    flag_z  = alu_flags_out[FLAG_Z];
    flag_c  = alu_flags_out[FLAG_C];
    flag_v  = alu_flags_out[FLAG_V];
    flag_n  = alu_flags_out[FLAG_N];
    sign_lt = flag_n ^ flag_v;

    derived[0] = flag_z;
    derived[1] = ~flag_z;
    derived[2] = ~flag_c;
    derived[3] = ~flag_c | flag_z;
    derived[4] = flag_c & ~flag_z;
    derived[5] = flag_c;
    derived[6] = sign_lt;
    derived[7] = sign_lt | flag_z;
    derived[8] = ~sign_lt & ~flag_z;
    derived[9] = ~sign_lt;

    golden[0] = (a_q == b_q);
    golden[1] = (a_q != b_q);
    golden[2] = (a_q <  b_q);
    golden[3] = (a_q <= b_q);
    golden[4] = (a_q >  b_q);
    golden[5] = (a_q >= b_q);
    golden[6] = ($signed(a_q) <  $signed(b_q));
    golden[7] = ($signed(a_q) <= $signed(b_q));
    golden[8] = ($signed(a_q) >  $signed(b_q));
    golden[9] = ($signed(a_q) >= $signed(b_q));

    mask = derived ^ golden;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic. Abort beats every busy-state transition, including
  // the CHECK -> DRIVE/DONE step, so the pair in CHECK is dropped.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (mode && (num_vectors == 32'd0)) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_DRIVE;
          end
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (LAT != 4'd0) begin
          state_nx = S_WAIT;
        end else begin
          state_nx = S_CHECK;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (lat_cnt_q == 4'd1) begin
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (abort) begin
          state_nx = S_IDLE;
        end else if (last_pair) begin
          state_nx = S_DONE;
        end else begin
          state_nx = S_DRIVE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand sequencing, latency counting, result counters and first-failure
  // capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q         <= '0;
      b_q         <= '0;
      lfsr_q      <= 32'd0;
      remaining_q <= 32'd0;
      lat_cnt_q   <= 4'd0;
      mode_q      <= 1'b0;
      vec_count   <= 32'd0;
      err_count   <= 16'd0;
      fail_valid  <= 1'b0;
      fail_a      <= '0;
      fail_b      <= '0;
      fail_flags  <= 4'd0;
      fail_mask   <= 10'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            mode_q      <= mode;
            remaining_q <= num_vectors;
            vec_count   <= 32'd0;
            err_count   <= 16'd0;
            fail_valid  <= 1'b0;
            fail_a      <= '0;
            fail_b      <= '0;
            fail_flags  <= 4'd0;
            fail_mask   <= 10'd0;
            if (mode) begin
              lfsr_q <= seed_eff;
              a_q    <= seed_eff[WIDTH-1:0];
              b_q    <= seed_eff[2*WIDTH-1:WIDTH];
            end else begin
              a_q <= '0;
              b_q <= '0;
            end
          end
        end
        S_DRIVE: begin
          lat_cnt_q <= LAT;
        end
        S_WAIT: begin
          lat_cnt_q <= lat_cnt_q - 4'd1;
        end
        S_CHECK: begin
          if (!abort) begin
            vec_count <= vec_count + 32'd1;
            if (mask != 10'd0) begin
              if (err_count != 16'hFFFF) begin
                err_count <= err_count + 16'd1;
              end
              if (!fail_valid) begin
                fail_valid <= 1'b1;
                fail_a     <= a_q;
                fail_b     <= b_q;
                fail_flags <= alu_flags_out;
                fail_mask  <= mask;
              end
            end
            if (mode_q) begin
              lfsr_q      <= lfsr_nx;
              a_q         <= lfsr_nx[WIDTH-1:0];
              b_q         <= lfsr_nx[2*WIDTH-1:WIDTH];
              remaining_q <= remaining_q - 32'd1;
            end else begin
              // b is the low half, so its wrap carries into a.
              {a_q, b_q} <= {a_q, b_q} + {{(2*WIDTH-1){1'b0}}, 1'b1};
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_compare_sweeper.sv
// tb_alu_compare_sweeper
// Scoreboard bench for alu_compare_sweeper at WIDTH=4, ALU_LATENCY=2. A
// behavioural ALU (integer arithmetic plus optional flag faults, delayed by
// a register pipeline) answers the DUT. Each sweep pushes its expected
// end-of-sweep results into a queue; a monitor pops and compares when done
// rises.
module tb_alu_compare_sweeper;

  localparam int W   = 4;
  localparam int LAT = 2;
  localparam int PER = LAT + 2;
  localparam int OW  = 4;
  localparam int SUB = 1;

  typedef struct {
    int vec;
    int err;
    int fvalid;
    int fa;
    int fb;
    int fflags;
    int fmask;
    int cycles;
    int start_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          mode = 1'b0;
  logic [31:0]   seed = 32'd0;
  logic [31:0]   num_vectors = 32'd0;
  logic [W-1:0]  alu_a, alu_b, fail_a, fail_b;
  logic [OW-1:0] alu_oper;
  logic [3:0]    alu_flags_in, alu_flags_out, fail_flags;
  logic          busy, done, fail_valid;
  logic [31:0]   vec_count;
  logic [15:0]   err_count;
  logic [9:0]    fail_mask;

  int   checks = 0;
  int   errors = 0;
  int   fault = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  logic [3:0] pipe [0:LAT];

  alu_compare_sweeper #(
    .WIDTH(W), .ALU_LATENCY(LAT), .OPER_WIDTH(OW), .OPER_SUB(SUB),
    .FLAG_Z(0), .FLAG_C(1), .FLAG_V(2), .FLAG_N(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .seed(seed), .num_vectors(num_vectors), .alu_a(alu_a), .alu_b(alu_b),
    .alu_oper(alu_oper), .alu_flags_in(alu_flags_in),
    .alu_flags_out(alu_flags_out), .busy(busy), .done(done),
    .vec_count(vec_count), .err_count(err_count), .fail_valid(fail_valid),
    .fail_a(fail_a), .fail_b(fail_b), .fail_flags(fail_flags),
    .fail_mask(fail_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Subtract flags from integer arithmetic; fault 1 forces C at (3,5),
  // fault 2 holds V at 0. Returned as {N,V,C,Z}.
  function automatic logic [3:0] ref_flags(int a, int b, int f);
    int m, d, sa, sb, r;
    logic z, c, n, v;
    m  = 1 << W;
    d  = (a - b + m) % m;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    r  = sa - sb;
    z  = (d == 0);
    c  = (a >= b);
    n  = (d >= m / 2);
    v  = (r < -(m / 2)) || (r > m / 2 - 1);
    if (f == 1 && a == 3 && b == 5) c = 1'b1;
    if (f == 2) v = 1'b0;
    return {n, v, c, z};
  endfunction

  function automatic logic [9:0] ref_mask(int a, int b, logic [3:0] fl);
    int m, sa, sb;
    logic z, c, v, n, lt;
    logic [9:0] der, gold;
    m  = 1 << W;
    sa = (a >= m / 2) ? a - m : a;
    sb = (b >= m / 2) ? b - m : b;
    z = fl[0]; c = fl[1]; v = fl[2]; n = fl[3];
    lt = (n != v);
    der  = {!lt && !z, (!lt) && !z ? 1'b1 : 1'b0, lt || z, lt, c, c && !z, !c || z, !c, !z, z};
    der[9] = !lt;
    der[8] = !lt && !z;
    gold = {sa >= sb, sa > sb, sa <= sb, sa < sb, a >= b, a > b, a <= b, a < b, a != b, a == b};
    return der ^ gold;
  endfunction

  function automatic logic [31:0] lfsr_next(logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  // Behavioural ALU: flags valid LAT+1 register stages after the operands.
  always @(posedge clk) begin
    pipe[0] <= ref_flags(int'(alu_a), int'(alu_b), fault);
    for (int i = 1; i <= LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_flags_out = pipe[LAT];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Expected results of the first `limit` pairs (limit < 0 means all).
  task automatic build_expect(input bit md, input logic [31:0] sd, input int num,
                              input int f, input int limit, output exp_t e);
    int total, a, b, wm;
    logic [31:0] l;
    logic [3:0] fl;
    logic [9:0] mk;
    wm = (1 << W) - 1;
    total = md ? num : (1 << (2 * W));
    if (limit >= 0 && limit < total) total = limit;
    l = (sd == 32'd0) ? 32'd1 : sd;
    e.vec = 0; e.err = 0; e.fvalid = 0; e.fa = 0; e.fb = 0;
    e.fflags = 0; e.fmask = 0; e.start_cyc = 0;
    for (int k = 0; k < total; k++) begin
      if (md) begin
        a = int'(l) & wm;
        b = int'(l >> W) & wm;
        l = lfsr_next(l);
      end else begin
        a = k >> W;
        b = k & wm;
      end
      fl = ref_flags(a, b, f);
      mk = ref_mask(a, b, fl);
      e.vec++;
      if (mk != 10'd0) begin
        if (e.err < 65535) e.err++;
        if (e.fvalid == 0) begin
          e.fvalid = 1; e.fa = a; e.fb = b; e.fflags = int'(fl); e.fmask = int'(mk);
        end
      end
    end
    e.cycles = total * PER;
  endtask

  // Issue one sweep, push its expectation, wait (bounded) for the monitor.
  // restart_at > 0 pulses start again that many cycles into the sweep.
  task automatic applyStimulus(input bit md, input logic [31:0] sd, input int num,
                               input int f, input int restart_at);
    exp_t e;
    int budget, n;
    fault = f;
    build_expect(md, sd, num, f, -1, e);
    @(negedge clk);
    mode = md; seed = sd; num_vectors = num; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.start_cyc = cyc;
    mode = ~md; seed = $urandom; num_vectors = $urandom;
    exp_q.push_back(e);
    budget = e.cycles + 20;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
      if (n == restart_at) begin
        #1 start = 1'b1;
        @(posedge clk);
        n++;
        #1 start = 1'b0;
      end
    end
    checkOutput("sweep_completed", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: compares results whenever done rises.
  logic done_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done && !done_seen) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("done_latency", cyc - e.start_cyc, e.cycles);
        checkOutput("vec_count", vec_count, e.vec);
        checkOutput("err_count", err_count, e.err);
        checkOutput("fail_valid", fail_valid, e.fvalid);
        checkOutput("fail_a", fail_a, e.fa);
        checkOutput("fail_b", fail_b, e.fb);
        checkOutput("fail_flags", fail_flags, e.fflags);
        checkOutput("fail_mask", fail_mask, e.fmask);
        checkOutput("busy_at_done", busy, 0);
      end
    end
    done_seen = done;
  end

  initial begin
    exp_t e;
    int k;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_vec", vec_count, 0);
    checkOutput("rst_err", err_count, 0);
    checkOutput("rst_fail_valid", fail_valid, 0);
    checkOutput("rst_alu_a", alu_a, 0);
    checkOutput("rst_alu_oper", alu_oper, SUB);
    checkOutput("rst_flags_in", alu_flags_in, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Exhaustive sweeps: correct ALU, C fault at (3,5), V stuck at 0.
    applyStimulus(1'b0, 32'd0, 0, 0, 0);
    applyStimulus(1'b0, 32'd0, 0, 1, 0);
    applyStimulus(1'b0, 32'd0, 0, 2, 0);

    // Random sweeps: zero seed behaves as seed 1, then random seeds.
    applyStimulus(1'b1, 32'd0, 300, 0, 0);
    applyStimulus(1'b1, $urandom, $urandom_range(100, 400), 2, 0);
    applyStimulus(1'b1, $urandom, $urandom_range(100, 400), 0, 0);

    // Abort landing on a CHECK edge: that pair is dropped, results retained.
    k = 300;
    fault = 1;
    build_expect(1'b0, 32'd0, 0, 1, (k - 1) / PER, e);
    @(negedge clk);
    mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (k - 1) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_vec", vec_count, e.vec);
    checkOutput("abort_err", err_count, e.err);
    checkOutput("abort_fail_valid", fail_valid, e.fvalid);
    checkOutput("abort_fail_a", fail_a, e.fa);
    checkOutput("abort_fail_b", fail_b, e.fb);
    checkOutput("abort_fail_mask", fail_mask, e.fmask);
    repeat (4) @(posedge clk);
    #1 checkOutput("abort_stays_idle", busy, 0);

    // Zero-length random sweep from IDLE: straight to DONE, results cleared.
    applyStimulus(1'b1, $urandom, 0, 0, 0);

    // Asynchronous reset in the middle of a sweep.
    fault = 1;
    @(negedge clk);
    mode = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (249) @(posedge clk);
    #3;
    checkOutput("pre_rst_busy", busy, 1);
    checkOutput("pre_rst_vec", vec_count, 250 / PER);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", busy, 0);
    checkOutput("async_rst_vec", vec_count, 0);
    checkOutput("async_rst_err", err_count, 0);
    checkOutput("async_rst_fail_valid", fail_valid, 0);
    checkOutput("async_rst_alu_b", alu_b, 0);
    checkOutput("async_rst_oper", alu_oper, SUB);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // A second start while busy must not disturb the sweep.
    applyStimulus(1'b0, 32'd0, 0, 1, 37);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
